// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_pkg;

  localparam int N_INPUTS  = 3;
  localparam int N_VECTORS = 8;

  typedef logic [N_VECTORS-1:0] truth_table_t;
  typedef logic [N_INPUTS-1:0]  vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam vec_t FIRST_VEC = 3'd0;
  localparam vec_t LAST_VEC  = 3'd7;

  // Return table t with the entry for vector idx replaced by v.
  function automatic truth_table_t tt_set_entry(input truth_table_t t,
                                                input vec_t         idx,
                                                input logic         v);
    truth_table_t r;
    r      = t;
    r[idx] = v;
    return r;
  endfunction

  // Bitwise difference between an observed and an expected table.
  function automatic truth_table_t tt_diff(input truth_table_t obs,
                                           input truth_table_t exp);
    return obs ^ exp;
  endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Settle-time counter: counts up while enabled, saturates at
// SETTLE_CYCLES-1 and flags terminal count; clear has priority.
module tt_settle_counter #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step until the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (en_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight input vectors of a 3-input gate, samples the gate
// output after a settle time and compares the captured truth table
// against an expected code latched at start.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic [2:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed,
  output logic [7:0] mismatch
);

  state_e       state_q;
  vec_t         idx_q;
  vec_t         dut_in_q;
  logic         busy_q;
  logic         done_q;
  logic         pass_q;
  truth_table_t obs_q;
  truth_table_t mism_q;
  truth_table_t exp_q;

  truth_table_t obs_d;
  vec_t         idx_inc_s;
  logic         cnt_clr_s;
  logic         cnt_en_s;
  logic         cnt_tc_s;

  // Settle counter only runs in SETTLE; anywhere else it is held at zero
  // so each new vector starts from a fresh count.
  always_comb begin
    cnt_en_s  = 1'b0;
    cnt_clr_s = 1'b1;
    if ((state_q == SETTLE) && !abort) begin
      cnt_en_s  = 1'b1;
      cnt_clr_s = 1'b0;
    end else begin
      cnt_en_s  = 1'b0;
      cnt_clr_s = 1'b1;
    end
  end

  tt_settle_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr_s),
    .en_i  (cnt_en_s),
    .tc_o  (cnt_tc_s)
  );

  // Observed table including the bit being sampled this cycle, so the
  // final comparison on entry to DONE already sees vector 7.
  always_comb begin
    obs_d     = tt_set_entry(obs_q, idx_q, dut_out);
    idx_inc_s = idx_q + 3'd1;
  end

  // Sweep FSM with all outputs registered; abort overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= FIRST_VEC;
      dut_in_q <= FIRST_VEC;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      obs_q    <= 8'h00;
      mism_q   <= 8'h00;
      exp_q    <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q  <= IDLE;
        idx_q    <= FIRST_VEC;
        dut_in_q <= FIRST_VEC;
        busy_q   <= 1'b0;
        pass_q   <= 1'b0;
        mism_q   <= 8'h00;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              exp_q    <= expected;
              obs_q    <= 8'h00;
              idx_q    <= FIRST_VEC;
              dut_in_q <= FIRST_VEC;
              busy_q   <= 1'b1;
              pass_q   <= 1'b0;
              mism_q   <= 8'h00;
              state_q  <= SETTLE;
            end else begin
              state_q <= state_q;
            end
          end
          SETTLE: begin
            if (cnt_tc_s) begin
              state_q <= SAMPLE;
            end else begin
              state_q <= SETTLE;
            end
          end
          SAMPLE: begin
            obs_q <= obs_d;
            if (idx_q == LAST_VEC) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= (obs_d == exp_q);
              mism_q  <= tt_diff(obs_d, exp_q);
            end else begin
              idx_q    <= idx_inc_s;
              dut_in_q <= idx_inc_s;
              state_q  <= SETTLE;
            end
          end
          default: begin
            state_q  <= IDLE;
            idx_q    <= FIRST_VEC;
            dut_in_q <= FIRST_VEC;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dut_in   = dut_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign observed = obs_q;
  assign mismatch = mism_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a scoreboard of expected
// sweep results. Two instances: SETTLE_CYCLES=4 (gate true on vectors
// 0 and 2) and SETTLE_CYCLES=1 (constant-1 gate).
module tb_truth_table_sweeper;

  localparam logic [7:0] GATE0_TT = 8'h05;
  localparam logic [7:0] GATE1_TT = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       sel;

  logic       dut_out0, dut_out1;
  logic [2:0] dut_in0, dut_in1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] obs0, obs1, mism0, mism1;

  logic [2:0] m_dut_in;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_obs, m_mism;

  truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .dut_out(dut_out0), .dut_in(dut_in0),
    .busy(busy0), .done(done0), .pass(pass0),
    .observed(obs0), .mismatch(mism0)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .dut_out(dut_out1), .dut_in(dut_in1),
    .busy(busy1), .done(done1), .pass(pass1),
    .observed(obs1), .mismatch(mism1)
  );

  assign dut_out0 = (dut_in0 == 3'd0) || (dut_in0 == 3'd2);
  assign dut_out1 = 1'b1;

  assign m_dut_in = sel ? dut_in1 : dut_in0;
  assign m_busy   = sel ? busy1   : busy0;
  assign m_done   = sel ? done1   : done0;
  assign m_pass   = sel ? pass1   : pass0;
  assign m_obs    = sel ? obs1    : obs0;
  assign m_mism   = sel ? mism1   : mism0;

  typedef struct {
    logic [7:0] obs;
    logic       pass;
    logic [7:0] mism;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start with the given code; optionally push the predicted result.
  task automatic start_sweep(input logic [7:0] code, input int s,
                             input logic [7:0] tbl, input bit push);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    expected = code;
    if (push) begin
      e.obs  = tbl;
      e.pass = (tbl == code);
      e.mism = tbl ^ code;
      e.lat  = 1 + 8 * (s + 1);
      sb.push_back(e);
    end
  endtask

  // Follow a sweep cycle by cycle until done (bounded), then pop and compare.
  task automatic monitor_sweep(input string tag, input int s,
                               input int restart_at, input logic [7:0] alt);
    exp_t e;
    int   lat;
    bit   vec_ok;
    lat    = 0;
    vec_ok = 1'b1;
    for (int k = 1; k <= 400 && lat == 0; k++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        lat = k;
      end else if (k <= 8 * (s + 1)) begin
        if (m_dut_in !== 3'((k - 1) / (s + 1)) || m_busy !== 1'b1) vec_ok = 1'b0;
      end
      if (restart_at != 0 && k == restart_at) begin
        start    = 1'b1;
        expected = alt;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, "_vec_seq"}, 32'(vec_ok), 32'd1);
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_observed"}, m_obs, e.obs);
    check({tag, "_pass"}, m_pass, e.pass);
    check({tag, "_mismatch"}, m_mism, e.mism);
    check({tag, "_busy_at_done"}, m_busy, 1'b0);
    check({tag, "_dut_in_hold"}, m_dut_in, 3'd7);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, m_done, 1'b0);
    check({tag, "_pass_held"}, m_pass, e.pass);
  endtask

  initial begin
    bit no_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = 8'h00;
    sel      = 1'b0;

    // Reset state
    #2;
    check("rst_dut_in", m_dut_in, 3'd0);
    check("rst_busy", m_busy, 1'b0);
    check("rst_done", m_done, 1'b0);
    check("rst_pass", m_pass, 1'b0);
    check("rst_observed", m_obs, 8'h00);
    check("rst_mismatch", m_mism, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", m_busy, 1'b0);

    // Passing sweep
    start_sweep(8'h05, 4, GATE0_TT, 1'b1);
    monitor_sweep("pass_sweep", 4, 0, 8'h00);

    // Failing sweep
    start_sweep(8'hA0, 4, GATE0_TT, 1'b1);
    monitor_sweep("fail_sweep", 4, 0, 8'h00);

    // abort together with start in DONE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", m_busy, 1'b0);
    check("abort_start_mismatch", m_mism, 8'h00);
    check("abort_start_dut_in", m_dut_in, 3'd0);
    repeat (5) @(negedge clk);
    check("abort_start_stays_idle", m_busy, 1'b0);

    // abort while idx==3
    start_sweep(8'h05, 4, GATE0_TT, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_pre_idx3", m_dut_in, 3'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", m_busy, 1'b0);
    check("abort_dut_in", m_dut_in, 3'd0);
    check("abort_pass", m_pass, 1'b0);
    check("abort_done", m_done, 1'b0);
    check("abort_partial_observed", m_obs, 8'h05);
    no_done = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (m_done !== 1'b0 || m_busy !== 1'b0) no_done = 1'b0;
    end
    check("abort_no_done", 32'(no_done), 32'd1);

    // Normal sweep after abort
    start_sweep(8'h05, 4, GATE0_TT, 1'b1);
    monitor_sweep("post_abort_sweep", 4, 0, 8'h00);

    // start re-pulsed and expected changed mid-sweep: ignored
    start_sweep(8'h05, 4, GATE0_TT, 1'b1);
    monitor_sweep("restart_ignored", 4, 10, 8'hFF);

    // abort in DONE clears a held pass
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_pass", m_pass, 1'b0);
    check("abort_done_busy", m_busy, 1'b0);

    // Asynchronous reset at idx==5
    start_sweep(8'h05, 4, GATE0_TT, 1'b0);
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_mid_pre_idx5", m_dut_in, 3'd5);
    check("rst_mid_pre_observed", m_obs, 8'h05);
    rst_n = 1'b0;
    #1;
    check("rst_mid_dut_in", m_dut_in, 3'd0);
    check("rst_mid_busy", m_busy, 1'b0);
    check("rst_mid_done", m_done, 1'b0);
    check("rst_mid_pass", m_pass, 1'b0);
    check("rst_mid_observed", m_obs, 8'h00);
    check("rst_mid_mismatch", m_mism, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_sweep(8'h05, 4, GATE0_TT, 1'b1);
    monitor_sweep("post_reset_sweep", 4, 0, 8'h00);

    // SETTLE_CYCLES=1 instance with constant-1 gate
    sel = 1'b1;
    start_sweep(8'hFF, 1, GATE1_TT, 1'b1);
    monitor_sweep("settle1_sweep", 1, 0, 8'h00);
    repeat (30) @(negedge clk);
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
